// File: rtl/fader_gain_if.sv
// Bundles the fader sample stream, gain control and status lines.
// The design drives the slave side; the upstream filter and control drive the master side.
interface fader_gain_if #(
   parameter int GAIN_W = 16
);
   logic signed [15:0]  faderIn;
   logic                sampleValid;
   logic [GAIN_W-1:0]   targetGain;
   logic                mute;
   logic signed [15:0]  faderOut;
   logic                faderValid;
   logic                rampActive;
   logic                clipFlag;
   logic [1:0]          dbgState;
   logic [GAIN_W-1:0]   dbgGain;

   modport master (
      output faderIn, sampleValid, targetGain, mute,
      input  faderOut, faderValid, rampActive, clipFlag, dbgState, dbgGain
   );

   modport slave (
      input  faderIn, sampleValid, targetGain, mute,
      output faderOut, faderValid, rampActive, clipFlag, dbgState, dbgGain
   );
endinterface

// File: rtl/fader_gain.sv
// Channel fader: ramped Q2.14 gain, 2-stage multiply/round/saturate pipeline, clip indicator.
// Optional clip-hold stretching is enabled with the macro FADER_CLIP_HOLD_EN.
module fader_gain #(
   parameter int                GAIN_W            = 16,
   parameter logic [GAIN_W-1:0] STEP              = GAIN_W'(16'h0100),
   parameter logic [GAIN_W-1:0] RESET_GAIN        = '0,
   parameter int                CLIP_HOLD_SAMPLES = 2400
) (
   input logic          clk,
   input logic          reset,
   fader_gain_if.slave  bus
);
   // Handshake: sampleValid is a one-cycle strobe with no backpressure; each strobe
   // yields exactly one faderValid strobe two clocks later, and one sample per clock is accepted.

   localparam int PW = GAIN_W + 17;
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] RAMP_UP   = 2'd1;
   localparam logic [1:0] RAMP_DOWN = 2'd2;
   localparam logic [1:0] MUTED     = 2'd3;
   localparam logic signed [PW-1:0] HALF = PW'(8192);
   localparam logic signed [PW-1:0] MAXV = PW'(32767);
   localparam logic signed [PW-1:0] MINV = PW'(-32768);

   logic [GAIN_W-1:0]    curGain, effTarget, nextGain, gainDiff;
   logic [1:0]           state, nextState;
   logic signed [PW-1:0] inExt, gainExt, product, prodReg, rounded;
   logic signed [15:0]   outReg, satVal;
   logic                 s1Valid, validReg, rampReg, clipReg, satHit;

   always_comb begin
      effTarget = bus.mute ? '0 : bus.targetGain;
      nextGain  = curGain;
      gainDiff  = '0;
      if (curGain < effTarget) begin
         gainDiff = effTarget - curGain;
         nextGain = curGain + ((gainDiff > STEP) ? STEP : gainDiff);
      end else if (curGain > effTarget) begin
         gainDiff = curGain - effTarget;
         nextGain = curGain - ((gainDiff > STEP) ? STEP : gainDiff);
      end
      // State reflects the gain after this sample's step has been applied
      if (nextGain < effTarget)      nextState = RAMP_UP;
      else if (nextGain > effTarget) nextState = RAMP_DOWN;
      else if (effTarget == '0)      nextState = MUTED;
      else                           nextState = IDLE;
   end

   always_comb begin
      inExt   = PW'(bus.faderIn);
      gainExt = PW'({1'b0, curGain});
      product = inExt * gainExt;
      // Adding half an LSB before the arithmetic shift rounds ties toward +inf
      rounded = (prodReg + HALF) >>> 14;
      satHit  = 1'b0;
      if (rounded > MAXV) begin
         satVal = 16'sh7FFF;
         satHit = 1'b1;
      end else if (rounded < MINV) begin
         satVal = -16'sh8000;
         satHit = 1'b1;
      end else begin
         satVal = rounded[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curGain  <= RESET_GAIN;
         state    <= IDLE;
         rampReg  <= 1'b0;
         prodReg  <= '0;
         s1Valid  <= 1'b0;
         outReg   <= '0;
         validReg <= 1'b0;
      end else begin
         s1Valid  <= bus.sampleValid;
         validReg <= s1Valid;
         if (bus.sampleValid) begin
            prodReg <= product;
            curGain <= nextGain;
            state   <= nextState;
            rampReg <= (nextState == RAMP_UP) || (nextState == RAMP_DOWN);
         end
         if (s1Valid) outReg <= satVal;
      end
   end

`ifdef FADER_CLIP_HOLD_EN
   localparam int CW = $clog2(CLIP_HOLD_SAMPLES + 1);
   logic [CW-1:0] holdCnt;

   // Each clean output after a clip consumes one hold count while the flag stays up
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         holdCnt <= '0;
         clipReg <= 1'b0;
      end else if (s1Valid) begin
         if (satHit) begin
            holdCnt <= CW'(CLIP_HOLD_SAMPLES);
            clipReg <= 1'b1;
         end else if (holdCnt != '0) begin
            holdCnt <= holdCnt - CW'(1);
            clipReg <= 1'b1;
         end else begin
            clipReg <= 1'b0;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        clipReg <= 1'b0;
      else if (s1Valid) clipReg <= satHit;
   end
`endif

   assign bus.faderOut   = outReg;
   assign bus.faderValid = validReg;
   assign bus.rampActive = rampReg;
   assign bus.clipFlag   = clipReg;
   assign bus.dbgState   = state;
   assign bus.dbgGain    = curGain;
endmodule

// File: tb/tb_fader_gain.sv
// Directed bench for fader_gain: driver tasks push expected outputs, a negedge monitor
// pops and checks value, clip flag and two-clock latency on every faderValid.
module tb_fader_gain;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   modelGain = 0;
   int   holdCnt = 0;
   logic [15:0] tgt = 16'h0000;
   logic        mu = 1'b0;
   logic [32:0] exp_q[$];   // {clip, out[15:0], issue cycle[15:0]}

   fader_gain_if #(.GAIN_W(16)) bus();

   fader_gain #(.GAIN_W(16), .CLIP_HOLD_SAMPLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit clipModel(input bit sat);
`ifdef FADER_CLIP_HOLD_EN
      if (sat) begin
         holdCnt = 4;
         return 1'b1;
      end
      if (holdCnt > 0) begin
         holdCnt--;
         return 1'b1;
      end
      return 1'b0;
`else
      return sat;
`endif
   endfunction

   task automatic issue(input int x, input int expOut, input bit expSat);
      int eff;
      int d;
      @(negedge clk);
      bus.faderIn     = 16'(x);
      bus.targetGain  = tgt;
      bus.mute        = mu;
      bus.sampleValid = 1'b1;
      exp_q.push_back({clipModel(expSat), 16'(expOut), 16'(cyc)});
      eff = mu ? 0 : int'(tgt);
      if (modelGain < eff) begin
         d = eff - modelGain;
         modelGain += (d > 256) ? 256 : d;
      end else if (modelGain > eff) begin
         d = modelGain - eff;
         modelGain -= (d > 256) ? 256 : d;
      end
   endtask

   task automatic sendM(input int x);
      longint p;
      longint r;
      bit     s;
      p = longint'(x) * longint'(modelGain);
      r = (p + 64'sd8192) >>> 14;
      s = 1'b0;
      if (r > 32767) begin
         r = 32767;
         s = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         s = 1'b1;
      end
      issue(x, int'(r), s);
   endtask

   task automatic sendExp(input int x, input int e, input bit s);
      issue(x, e, s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.sampleValid = 1'b0;
      end
   endtask

   task automatic checkRegs(input string tag, input int gain, input int st, input int ramp);
      check({tag, "_gain"}, int'(bus.dbgGain), gain);
      check({tag, "_state"}, int'(bus.dbgState), st);
      check({tag, "_ramp"}, int'(bus.rampActive), ramp);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      bus.sampleValid = 1'b0;
      exp_q.delete();
      modelGain = 0;
      holdCnt = 0;
      @(negedge clk);
      check("rst_out", int'(bus.faderOut), 0);
      check("rst_valid", int'(bus.faderValid), 0);
      check("rst_clip", int'(bus.clipFlag), 0);
      checkRegs("rst", 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: every output strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      logic [32:0] e;
      logic [15:0] lat;
      if (!reset && bus.faderValid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got faderValid=1 with out=%0d, required no strobe", bus.faderOut);
         end else begin
            e = exp_q.pop_front();
            lat = 16'(cyc) - e[15:0];
            check("out", int'(bus.faderOut), int'($signed(e[31:16])));
            check("clip", int'(bus.clipFlag), int'(e[32]));
            check("latency", int'(lat), 2);
         end
      end
   end

   initial begin
      int sine[16] = '{0, 6270, 11585, 15136, 16383, 15136, 11585, 6270,
                       0, -6270, -11585, -15136, -16383, -15136, -11585, -6270};
      int sparse[6] = '{1234, -4321, 32767, -32768, 7, -1};
      reset = 1'b1;
      bus.faderIn = '0;
      bus.sampleValid = 1'b0;
      bus.targetGain = '0;
      bus.mute = 1'b0;
      repeat (2) @(negedge clk);
      check("init_out", int'(bus.faderOut), 0);
      check("init_valid", int'(bus.faderValid), 0);
      check("init_clip", int'(bus.clipFlag), 0);
      checkRegs("init", 0, 0, 0);
      reset = 1'b0;

      // Fade-in from silence: 64 strobes of 0x100
      tgt = 16'h4000;
      mu = 1'b0;
      sendExp(16383, 0, 1'b0);
      repeat (62) sendM(16383);
      idle(1);
      checkRegs("fade63", 16'h3F00, 1, 1);
      sendM(16383);
      idle(1);
      checkRegs("fade64", 16'h4000, 0, 0);
      sendExp(16383, 16383, 1'b0);

      // Unity gain reproduces the input exactly
      foreach (sine[i]) sendExp(sine[i], sine[i], 1'b0);
      idle(3);

      // Saturation at gain 2.0
      tgt = 16'h8000;
      repeat (64) sendM(100);
      idle(1);
      checkRegs("gain2", 16'h8000, 0, 0);
      sendExp(20000, 32767, 1'b1);
      sendExp(-20000, -32768, 1'b1);
      sendExp(1000, 2000, 1'b0);
      sendExp(-1000, -2000, 1'b0);
      sendExp(1000, 2000, 1'b0);
      sendExp(1000, 2000, 1'b0);
      sendExp(1000, 2000, 1'b0);
      sendExp(1000, 2000, 1'b0);
      idle(3);

      // Mute mid-ramp, rounding ties, release
      doReset();
      tgt = 16'h4000;
      repeat (32) sendM(1000);
      idle(1);
      checkRegs("up2000", 16'h2000, 1, 1);
      mu = 1'b1;
      sendExp(3, 2, 1'b0);
      sendExp(-3, -1, 1'b0);
      repeat (29) sendM(1000);
      idle(1);
      checkRegs("down100", 16'h0100, 2, 1);
      sendM(1000);
      idle(1);
      checkRegs("muted", 0, 3, 0);
      sendExp(12345, 0, 1'b0);
      idle(1);
      mu = 1'b0;
      sendExp(12345, 0, 1'b0);
      idle(1);
      checkRegs("unmute", 16'h0100, 1, 1);

      // Target changes: zero target, no overshoot, immediate reversal
      tgt = 16'h0000;
      sendM(1000);
      idle(1);
      checkRegs("tgt0", 0, 3, 0);
      tgt = 16'h0080;
      sendM(1000);
      idle(1);
      checkRegs("small", 16'h0080, 0, 0);
      tgt = 16'h4000;
      sendM(1000);
      sendM(1000);
      idle(1);
      checkRegs("up280", 16'h0280, 1, 1);
      tgt = 16'h0100;
      sendM(-2000);
      idle(1);
      checkRegs("reverse", 16'h0180, 2, 1);

      // Sparse strobes every 4th clock
      foreach (sparse[i]) begin
         sendM(sparse[i]);
         idle(3);
      end

      // Reset one clock after a strobe discards the in-flight sample
      sendM(777);
      doReset();
      idle(6);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
